// File: rtl/hamming_uart_link.sv
// hamming_uart_link
//   Transmit path for a pin-limited chip. A rising edge on start encodes the
//   data_in nibble with a Hamming(7,4) code. The codeword is zero-extended to
//   8 bits and sent as one UART 8N1 frame on tx. A free-running 3-bit counter
//   is provided for bring-up.
//
// Ports
//   clk        : system clock, rising edge
//   rst_n      : asynchronous active-low reset
//   start      : level input; each rising edge requests one encode + transmit
//   data_in    : nibble d3..d0 to encode
//   tx         : registered UART line, idles high
//   tx_busy    : high while a frame is on the line
//   code_out   : last encoded codeword {d3,d2,d1,p4,d0,p2,p1}
//   code_valid : one-cycle pulse when code_out has been updated
//   count      : free-running debug counter, wraps 7 -> 0
//
// Handshake: there is no back-pressure. A start edge is always encoded.
// tx_start is the leading edge of code_valid. It launches a frame only when
// the serializer is in IDLE. If it arrives in any other state it is dropped
// and is not queued; code_out still shows the new codeword.
module hamming_uart_link #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] data_in,
  output logic       tx,
  output logic       tx_busy,
  output logic [6:0] code_out,
  output logic       code_valid,
  output logic [2:0] count
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START_BIT = 2'd1,
    DATA_BITS = 2'd2,
    STOP_BIT  = 2'd3
  } state_t;

  function automatic logic [6:0] hamming_encode(input logic [3:0] d);
    logic [6:0] c;
    c[0] = d[0] ^ d[1] ^ d[3];
    c[1] = d[0] ^ d[2] ^ d[3];
    c[2] = d[0];
    c[3] = d[1] ^ d[2] ^ d[3];
    c[4] = d[1];
    c[5] = d[2];
    c[6] = d[3];
    return c;
  endfunction

  // ---------------------------------------------------------------- edge/encode
  logic       start_d;
  logic       req;
  logic       code_valid_d;
  logic       tx_start;
  logic [6:0] code_q;
  logic       code_valid_q;

  assign req      = start & ~start_d;
  assign tx_start = code_valid_q & ~code_valid_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_d      <= 1'b0;
      code_q       <= '0;
      code_valid_q <= 1'b0;
      code_valid_d <= 1'b0;
    end else begin
      start_d      <= start;
      code_valid_q <= req;
      code_valid_d <= code_valid_q;
      if (req) code_q <= hamming_encode(data_in);
    end
  end

  assign code_out   = code_q;
  assign code_valid = code_valid_q;

  // ---------------------------------------------------------------- serializer
  state_t          state, state_n;
  logic [CW-1:0]   baud_cnt, baud_n;
  logic [2:0]      bit_idx, bit_n;
  logic [7:0]      shreg, shreg_n;
  logic            tx_q, tx_n;
  logic            bit_end;

  assign bit_end = (baud_cnt == BAUD_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      tx_q     <= 1'b1;
    end else begin
      state    <= state_n;
      baud_cnt <= baud_n;
      bit_idx  <= bit_n;
      shreg    <= shreg_n;
      tx_q     <= tx_n;
    end
  end

  // tx_n is the line value for the state being entered. This keeps tx
  // registered and aligned with the state register.
  always_comb begin
    state_n = state;
    baud_n  = baud_cnt;
    bit_n   = bit_idx;
    shreg_n = shreg;
    tx_n    = tx_q;
    case (state)
      IDLE: begin
        tx_n   = 1'b1;
        baud_n = '0;
        bit_n  = '0;
        if (tx_start) begin
          shreg_n = {1'b0, code_q};
          state_n = START_BIT;
          tx_n    = 1'b0;
        end
      end
      START_BIT: begin
        if (bit_end) begin
          baud_n  = '0;
          state_n = DATA_BITS;
          tx_n    = shreg[0];
        end else begin
          baud_n = baud_cnt + CW'(1);
        end
      end
      DATA_BITS: begin
        if (bit_end) begin
          baud_n = '0;
          if (bit_idx == 3'd7) begin
            state_n = STOP_BIT;
            tx_n    = 1'b1;
          end else begin
            bit_n   = bit_idx + 3'd1;
            shreg_n = shreg >> 1;
            tx_n    = shreg[1];
          end
        end else begin
          baud_n = baud_cnt + CW'(1);
        end
      end
      STOP_BIT: begin
        if (bit_end) begin
          baud_n  = '0;
          state_n = IDLE;
          tx_n    = 1'b1;
        end else begin
          baud_n = baud_cnt + CW'(1);
        end
      end
      default: begin
        state_n = IDLE;
        tx_n    = 1'b1;
      end
    endcase
  end

  assign tx      = tx_q;
  assign tx_busy = (state != IDLE);

  // ---------------------------------------------------------------- debug count
  logic [2:0] count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_q + 3'd1;
  end

  assign count = count_q;

endmodule

// File: tb/tb_hamming_uart_link.sv
// Bench for hamming_uart_link. Expected codewords and frame bytes are pushed
// into queues when stimulus is issued. Independent monitors pop the queues
// when the DUT presents a codeword or completes a frame on tx.
module tb_hamming_uart_link;

  localparam int CPB   = 16;
  localparam int FRAME = 10 * CPB;

  // ---------------------------------------------------------------- clock/reset
  logic       clk     = 1'b0;
  logic       rst_n   = 1'b0;
  logic       start   = 1'b0;
  logic [3:0] data_in = 4'h0;
  logic       tx;
  logic       tx_busy;
  logic [6:0] code_out;
  logic       code_valid;
  logic [2:0] count;

  always #5 clk = ~clk;

  hamming_uart_link #(.CLKS_PER_BIT(CPB)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .data_in    (data_in),
    .tx         (tx),
    .tx_busy    (tx_busy),
    .code_out   (code_out),
    .code_valid (code_valid),
    .count      (count)
  );

  // ---------------------------------------------------------------- scoreboard
  int n_vec = 0;
  int n_err = 0;
  logic [6:0] exp_code_q[$];
  logic [7:0] exp_frame_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  // Codeword monitor
  logic cv_prev = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) cv_prev = 1'b0;
    else begin
      if (code_valid) begin
        check("code_valid_width", {31'd0, cv_prev}, 32'd0);
        if (exp_code_q.size() == 0) fail_now("unexpected_code_valid");
        else check("code_out", {25'd0, code_out}, {25'd0, exp_code_q.pop_front()});
      end
      cv_prev = code_valid;
    end
  end

  // Frame decoder: samples tx mid-bit relative to the first low sample
  int         fr_cnt    = 0;
  int         fr_k      = 0;
  bit         fr_active = 1'b0;
  logic [9:0] fr_bits   = '0;
  always @(negedge clk) begin
    if (!rst_n) fr_active = 1'b0;
    else begin
      if (!fr_active && tx == 1'b0) begin
        fr_active = 1'b1;
        fr_cnt    = 0;
        fr_bits   = '0;
      end else if (fr_active) begin
        fr_cnt++;
      end
      if (fr_active && fr_cnt >= CPB/2 && ((fr_cnt - CPB/2) % CPB) == 0) begin
        fr_k = (fr_cnt - CPB/2) / CPB;
        fr_bits[fr_k] = tx;
        if (fr_k == 9) begin
          fr_active = 1'b0;
          check("frame_start_bit", {31'd0, fr_bits[0]}, 32'd0);
          check("frame_stop_bit", {31'd0, fr_bits[9]}, 32'd1);
          if (exp_frame_q.size() == 0) fail_now("unexpected_frame");
          else check("frame_byte", {24'd0, fr_bits[8:1]}, {24'd0, exp_frame_q.pop_front()});
        end
      end
    end
  end

  // Busy-length monitor
  int busy_len = 0;
  always @(negedge clk) begin
    if (!rst_n) busy_len = 0;
    else if (tx_busy) busy_len++;
    else if (busy_len != 0) begin
      check("tx_busy_length", busy_len, FRAME);
      busy_len = 0;
    end
  end

  // Counter monitor
  logic [2:0] cnt_prev = '0;
  bit         cnt_ok   = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) cnt_ok = 1'b0;
    else begin
      if (cnt_ok) check("count_step", {29'd0, count}, {29'd0, cnt_prev + 3'd1});
      cnt_prev = count;
      cnt_ok   = 1'b1;
    end
  end

  // ---------------------------------------------------------------- drivers
  task automatic pulse(input logic [3:0] d, input logic [6:0] c, input bit frame);
    @(negedge clk);
    data_in = d;
    start   = 1'b1;
    exp_code_q.push_back(c);
    if (frame) exp_frame_q.push_back({1'b0, c});
    @(negedge clk);            // cycle 1
    start = 1'b0;
    check("code_valid_cycle1", {31'd0, code_valid}, 32'd1);
    if (frame) check("tx_idle_cycle1", {31'd0, tx}, 32'd1);
    @(negedge clk);            // cycle 2
    check("code_valid_cycle2", {31'd0, code_valid}, 32'd0);
    if (frame) begin
      check("tx_start_cycle2", {31'd0, tx}, 32'd0);
      check("tx_busy_cycle2", {31'd0, tx_busy}, 32'd1);
    end
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (tx_busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (tx_busy) fail_now("idle_timeout");
    repeat (20) @(negedge clk);
  endtask

  logic [3:0] vec_d[5] = '{4'h0, 4'h1, 4'hB, 4'hF, 4'h6};
  logic [6:0] vec_c[5] = '{7'h00, 7'h07, 7'h55, 7'h7F, 7'h33};

  initial begin
    #2_000_000;
    $display("FAIL watchdog at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset
    rst_n = 1'b0;
    repeat (4) @(negedge clk);
    check("rst_tx", {31'd0, tx}, 32'd1);
    check("rst_tx_busy", {31'd0, tx_busy}, 32'd0);
    check("rst_count", {29'd0, count}, 32'd0);
    check("rst_code_out", {25'd0, code_out}, 32'd0);
    check("rst_code_valid", {31'd0, code_valid}, 32'd0);
    rst_n = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      check("count_after_reset", {29'd0, count}, i % 8);
    end

    // Encode vectors, each sent as a full frame
    for (int i = 0; i < 5; i++) begin
      pulse(vec_d[i], vec_c[i], 1'b1);
      wait_idle(FRAME + 20);
    end

    // Held start: one frame only
    @(negedge clk);
    data_in = 4'hB;
    start   = 1'b1;
    exp_code_q.push_back(7'h55);
    exp_frame_q.push_back(8'h55);
    repeat (500) @(negedge clk);
    start = 1'b0;
    wait_idle(FRAME + 20);
    check("held_frames_left", exp_frame_q.size(), 0);
    check("held_codes_left", exp_code_q.size(), 0);

    // Busy collision: second request is encoded but not transmitted
    pulse(4'hB, 7'h55, 1'b1);
    repeat (40) @(negedge clk);
    pulse(4'hF, 7'h7F, 1'b0);
    wait_idle(FRAME + 20);
    repeat (200) @(negedge clk);
    check("collision_code_out", {25'd0, code_out}, 32'h7F);
    check("collision_frames_left", exp_frame_q.size(), 0);
    check("collision_busy", {31'd0, tx_busy}, 32'd0);

    // Reset in the middle of data bit 3
    pulse(4'hB, 7'h55, 1'b1);
    repeat (72) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_tx", {31'd0, tx}, 32'd1);
    check("midrst_tx_busy", {31'd0, tx_busy}, 32'd0);
    check("midrst_code_out", {25'd0, code_out}, 32'd0);
    check("midrst_count", {29'd0, count}, 32'd0);
    exp_code_q.delete();
    exp_frame_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    pulse(4'h6, 7'h33, 1'b1);
    wait_idle(FRAME + 20);
    check("post_reset_frames_left", exp_frame_q.size(), 0);
    check("post_reset_codes_left", exp_code_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/hamming_uart_link.md
Name: hamming_uart_link

Overview:
- Self-contained transmit path: 4-bit nibble -> Hamming(7,4) encoder -> zero-extended to 8 bits -> UART 8N1 serializer on a single TX line.
- A free-running 3-bit debug counter is included.
- The block is the core of a small I/O-pin-limited chip. Its inputs come from switches/pins; tx drives an output pin.

Parameters:
- CLKS_PER_BIT, default 16: clk cycles per UART bit; legal range 2..65535.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  level input; its rising edge (sampled in clk) requests one encode+transmit.
- data_in  input  4  nibble to encode, d3..d0.
- tx  output  1  UART serial line; idles high.
- tx_busy  output  1  high while a frame is in progress.
- code_out  output  7  registered Hamming codeword, last encoded.
- code_valid  output  1  one-cycle pulse when code_out is updated.
- count  output  3  free-running debug counter.

Behaviour:
Reset (rst_n=0, async):
- Required values: tx=1, tx_busy=0, code_out=0, code_valid=0, count=0.
- The start edge-detect register and the valid-delay register are cleared.
- UART FSM goes to IDLE.
- Reset mid-frame aborts the frame: tx returns to 1 immediately and the nibble is discarded.

Edge detect:
- start_d is registered start.
- req = start & ~start_d, combinational.
- A level held high yields exactly one req.

Encoder:
- On a clk edge with req=1, register code_out from data_in and set code_valid=1 for exactly one cycle.
- Codeword bits (d = data_in):
  - code_out[0] = p1 = d0^d1^d3
  - code_out[1] = p2 = d0^d2^d3
  - code_out[2] = d0
  - code_out[3] = p4 = d1^d2^d3
  - code_out[4] = d1
  - code_out[5] = d2
  - code_out[6] = d3
- code_out holds its value until the next req.
- A req while the UART is busy still updates code_out and pulses code_valid.

UART launch:
- tx_start = code_valid & ~code_valid_d, where code_valid_d is code_valid delayed one cycle.
- tx_data = {1'b0, code_out}.
- On tx_start in IDLE, latch tx_data and enter START. tx_busy=1 from the next cycle.
- tx_start while not IDLE is ignored; no queuing.

UART FSM states:
- IDLE: tx=1, tx_busy=0.
- START: tx=0 for CLKS_PER_BIT cycles.
- DATA: 8 bits LSB first, each held CLKS_PER_BIT cycles; a 3-bit bit index counts 0..7.
- STOP: tx=1 for CLKS_PER_BIT cycles.
- After STOP, return to IDLE with tx_busy=0.
- Frame length is exactly 10*CLKS_PER_BIT cycles.
- The baud counter resets at every bit boundary.
- tx is registered, so there are no glitches.

Latency:
- Let cycle 0 be the cycle where start rises.
- code_valid=1 in cycle 1.
- tx falls (start bit) and tx_busy rises in cycle 2.
- Back-to-back: a req accepted in the same cycle the FSM returns to IDLE starts a new frame. The stop bit is never shortened.

Counter:
- count increments by 1 every clk cycle, wrapping 7 -> 0.
- It is independent of all other logic.

Test Plan:
- Reset: hold rst_n=0 with clk running -> tx=1, tx_busy=0, count=0, code_out=0, code_valid=0. Release -> count = 1,2,...,7,0 on successive cycles.
- Encode vectors: data_in = 0x0, 0x1, 0xB, 0xF, each with a start pulse -> code_out = 0x00, 0x07, 0x55, 0x7F respectively. code_valid high exactly 1 cycle, in cycle 1.
- Frame check, CLKS_PER_BIT=16, data_in=0xB: sample tx mid-bit from cycle 2.
  - Required sequence: 0 (start), then 1,0,1,0,1,0,1,0 (0x55 LSB first), then 1 (stop).
  - tx_busy high for 160 cycles.
- Held start: keep start=1 for 500 cycles -> exactly one frame sent.
- Busy collision: second start rise during a frame with data_in=0xF.
  - code_out becomes 0x7F.
  - The in-flight frame completes unchanged and no second frame is sent.
- Reset mid-frame: assert rst_n=0 during DATA bit 3 -> tx=1 and tx_busy=0 asynchronously. After release, a new start sends a complete, correct frame.
